// File: rtl/arrow_lane_sequencer.sv
// Scrolling arrow lane for one player: paces the 26-slot arrow shift register,
// pulls chart arrows through a valid/ready handshake, and judges presses near the target.
module arrow_lane_sequencer #(
    parameter int unsigned NUM_SLOTS      = 26,
    parameter int unsigned STEP_CYCLES    = 3125000,
    parameter int unsigned HOLD_CYCLES    = 25000000,
    parameter int unsigned EXCELLENT_SLOT = 25,
    parameter int unsigned GOOD_SLOT      = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [2:0]               next_arrow,
    input  logic                     next_valid,
    output logic                     next_ready,
    input  logic [2:0]               press,
    input  logic                     press_valid,
    output logic [3*NUM_SLOTS-1:0]   arrow_array,
    output logic [1:0]               indicator,
    output logic [15:0]              score,
    output logic [7:0]               miss_count
);

    localparam int unsigned STEP_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS);
    localparam int unsigned LOW_SLOT = GOOD_SLOT - 1;

    typedef enum logic [1:0] {
        IND_NONE      = 2'b00,
        IND_BAD       = 2'b01,
        IND_GOOD      = 2'b10,
        IND_EXCELLENT = 2'b11
    } judge_t;

    logic [2:0]        slots      [NUM_SLOTS];
    logic [2:0]        judged     [NUM_SLOTS];
    logic [2:0]        slots_next [NUM_SLOTS];
    logic [STEP_W-1:0] step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    judge_t            ind_q;
    judge_t            ind_next;
    logic              tick;
    logic              judge;
    logic              hit;
    logic [SLOT_W-1:0] hit_idx;
    logic              miss;
    logic              event_seen;
    logic [1:0]        score_inc;
    logic [16:0]       score_sum;
    logic [15:0]       score_next;
    logic [7:0]        miss_next;

    always_comb begin
        tick  = enable && !clear && (step_cnt == STEP_W'(STEP_CYCLES - 1));
        judge = enable && !clear && press_valid && (press != 3'b000);
    end

    assign next_ready = tick;

    // Ascending scan so the highest-numbered match is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = LOW_SLOT; k < NUM_SLOTS; k++) begin
            if (judge && (slots[k] == press)) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(k);
            end
        end
    end

    // The matched arrow is removed before the shift, so it cannot also count as a miss.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            judged[k] = (hit && (hit_idx == SLOT_W'(k))) ? 3'b000 : slots[k];
        end
        miss = tick && (judged[NUM_SLOTS-1] != 3'b000);
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            slots_next[k] = judged[k];
        end
        if (tick) begin
            slots_next[0] = next_valid ? next_arrow : 3'b000;
            for (int unsigned k = 1; k < NUM_SLOTS; k++) begin
                slots_next[k] = judged[k-1];
            end
        end
    end

    always_comb begin
        ind_next  = IND_NONE;
        score_inc = 2'd0;
        if (hit && (hit_idx == SLOT_W'(EXCELLENT_SLOT))) begin
            ind_next  = IND_EXCELLENT;
            score_inc = 2'd2;
        end else if (hit && (hit_idx == SLOT_W'(GOOD_SLOT))) begin
            ind_next  = IND_GOOD;
            score_inc = 2'd1;
        end else if (judge || miss) begin
            ind_next = IND_BAD;
        end
        event_seen = judge || miss;
    end

    always_comb begin
        score_sum  = {1'b0, score} + 17'(score_inc);
        score_next = score_sum[16] ? '1 : score_sum[15:0];
        miss_next  = (miss && (miss_count != '1)) ? miss_count + 8'd1 : miss_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                slots[k] <= 3'b000;
            end
            step_cnt   <= '0;
            hold_cnt   <= '0;
            ind_q      <= IND_NONE;
            score      <= '0;
            miss_count <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                slots[k] <= 3'b000;
            end
            step_cnt   <= '0;
            hold_cnt   <= '0;
            ind_q      <= IND_NONE;
            score      <= '0;
            miss_count <= '0;
        end else begin
            if (enable) begin
                step_cnt <= tick ? '0 : step_cnt + 1'b1;
            end
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                slots[k] <= slots_next[k];
            end
            score      <= score_next;
            miss_count <= miss_next;
            // Hold counter runs regardless of pause so a judgement always fades out.
            if (event_seen) begin
                ind_q    <= ind_next;
                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end else begin
                ind_q <= IND_NONE;
            end
        end
    end

    always_comb begin
        arrow_array = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            arrow_array[3*k +: 3] = slots[k];
        end
    end

    assign indicator = ind_q;

endmodule

// File: tb/tb_arrow_lane_sequencer.sv
// Directed bench for arrow_lane_sequencer: short step/hold lane for timing scenarios,
// plus a fast-step lane driven to score saturation.
module tb_arrow_lane_sequencer;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, enable, clear, next_valid, next_ready, press_valid;
    logic [2:0]  next_arrow, press;
    logic [77:0] arrow_array;
    logic [1:0]  indicator;
    logic [15:0] score;
    logic [7:0]  miss_count;

    logic        reset_s, enable_s, clear_s, next_valid_s, next_ready_s, press_valid_s;
    logic [2:0]  next_arrow_s, press_s;
    logic [77:0] arrow_array_s;
    logic [1:0]  indicator_s;
    logic [15:0] score_s;
    logic [7:0]  miss_count_s;

    int checks = 0;
    int passes = 0;

    arrow_lane_sequencer #(.STEP_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .next_arrow(next_arrow), .next_valid(next_valid), .next_ready(next_ready),
        .press(press), .press_valid(press_valid), .arrow_array(arrow_array),
        .indicator(indicator), .score(score), .miss_count(miss_count)
    );

    arrow_lane_sequencer #(.STEP_CYCLES(2), .HOLD_CYCLES(8)) dut_sat (
        .clock(clock), .reset(reset_s), .enable(enable_s), .clear(clear_s),
        .next_arrow(next_arrow_s), .next_valid(next_valid_s), .next_ready(next_ready_s),
        .press(press_s), .press_valid(press_valid_s), .arrow_array(arrow_array_s),
        .indicator(indicator_s), .score(score_s), .miss_count(miss_count_s)
    );

    function automatic logic [2:0] slot_of(input logic [77:0] a, input int unsigned k);
        return a[3*k +: 3];
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; clear = 1'b0;
        next_valid = 1'b0; next_arrow = 3'b000; press = 3'b000; press_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (next_ready !== 1'b1 && n < 16) begin
            cycle();
            n++;
        end
        if (next_ready !== 1'b1) begin
            checks++;
            $display("FAIL wait_ready: next_ready=%b after %0d cycles, required 1", next_ready, n);
        end
    endtask

    task automatic wait_ready_s();
        int n = 0;
        while (next_ready_s !== 1'b1 && n < 16) begin
            cycle();
            n++;
        end
        if (next_ready_s !== 1'b1) begin
            checks++;
            $display("FAIL wait_ready_s: next_ready=%b after %0d cycles, required 1", next_ready_s, n);
        end
    endtask

    task automatic do_tick(input logic [2:0] code, input logic valid);
        wait_ready();
        next_arrow = code;
        next_valid = valid;
        cycle();
        next_valid = 1'b0;
        next_arrow = 3'b000;
    endtask

    task automatic place(input logic [2:0] code, input int unsigned slot);
        do_tick(code, 1'b1);
        repeat (slot) do_tick(3'b000, 1'b0);
    endtask

    task automatic hit(input logic [2:0] code);
        press = code;
        press_valid = 1'b1;
        cycle();
        press_valid = 1'b0;
        press = 3'b000;
    endtask

    task automatic test_reset();
        reset_s = 1'b1; enable_s = 1'b1; clear_s = 1'b0;
        next_valid_s = 1'b1; next_arrow_s = 3'b001; press_s = 3'b001; press_valid_s = 1'b0;
        do_reset();
        reset = 1'b1;
        #1;
        checks++; if (arrow_array !== '0) $display("FAIL reset_array: got %h want 0", arrow_array); else passes++;
        checks++; if (indicator !== 2'b00) $display("FAIL reset_indicator: got %b want 00", indicator); else passes++;
        checks++; if (score !== 16'h0) $display("FAIL reset_score: got %h want 0000", score); else passes++;
        checks++; if (miss_count !== 8'h0) $display("FAIL reset_miss: got %h want 00", miss_count); else passes++;
        checks++; if (next_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", next_ready); else passes++;
    endtask

    task automatic test_handshake();
        logic [77:0] exp_arr;
        do_reset();
        next_valid = 1'b1;
        next_arrow = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            checks++;
            if (next_ready !== ((k % 4) == 3))
                $display("FAIL hs_ready_c%0d: got %b want %b", k, next_ready, (k % 4) == 3);
            else passes++;
            if (k == 4) begin
                checks++;
                if (arrow_array[2:0] !== 3'b001) $display("FAIL hs_slot0: got %b want 001", arrow_array[2:0]);
                else passes++;
                next_valid = 1'b0;
                next_arrow = 3'b000;
            end
        end
        repeat (23) do_tick(3'b000, 1'b0);
        exp_arr = '0;
        exp_arr[77:75] = 3'b001;
        checks++; if (arrow_array !== exp_arr) $display("FAIL hs_slot25: got %h want %h", arrow_array, exp_arr); else passes++;
    endtask

    task automatic test_excellent();
        do_reset();
        place(3'b010, 25);
        hit(3'b010);
        checks++; if (indicator !== 2'b11) $display("FAIL exc_indicator: got %b want 11", indicator); else passes++;
        checks++; if (score !== 16'd2) $display("FAIL exc_score: got %0d want 2", score); else passes++;
        checks++; if (slot_of(arrow_array, 25) !== 3'b000) $display("FAIL exc_slot25: got %b want 000", slot_of(arrow_array, 25)); else passes++;
        do_tick(3'b000, 1'b0);
        checks++; if (miss_count !== 8'd0) $display("FAIL exc_miss: got %0d want 0", miss_count); else passes++;
        place(3'b011, 2);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        checks++; if (score !== 16'd0) $display("FAIL clear_score: got %0d want 0", score); else passes++;
        checks++; if (arrow_array !== '0) $display("FAIL clear_array: got %h want 0", arrow_array); else passes++;
        checks++; if (indicator !== 2'b00) $display("FAIL clear_indicator: got %b want 00", indicator); else passes++;
    endtask

    task automatic test_good_bad();
        do_reset();
        do_tick(3'b011, 1'b1);
        do_tick(3'b100, 1'b1);
        repeat (23) do_tick(3'b000, 1'b0);
        hit(3'b011);
        checks++; if (indicator !== 2'b10) $display("FAIL good_indicator: got %b want 10", indicator); else passes++;
        checks++; if (score !== 16'd1) $display("FAIL good_score: got %0d want 1", score); else passes++;
        checks++; if (slot_of(arrow_array, 24) !== 3'b000) $display("FAIL good_slot24: got %b want 000", slot_of(arrow_array, 24)); else passes++;
        checks++; if (slot_of(arrow_array, 23) !== 3'b100) $display("FAIL good_slot23: got %b want 100", slot_of(arrow_array, 23)); else passes++;
        hit(3'b100);
        checks++; if (indicator !== 2'b01) $display("FAIL bad_indicator: got %b want 01", indicator); else passes++;
        checks++; if (score !== 16'd1) $display("FAIL bad_score: got %0d want 1", score); else passes++;
        checks++; if (arrow_array !== '0) $display("FAIL bad_cleared: got %h want 0", arrow_array); else passes++;
        repeat (10) cycle();
        checks++; if (indicator !== 2'b00) $display("FAIL bad_faded: got %b want 00", indicator); else passes++;
        hit(3'b001);
        checks++; if (indicator !== 2'b01) $display("FAIL nomatch_indicator: got %b want 01", indicator); else passes++;
        checks++; if (score !== 16'd1) $display("FAIL nomatch_score: got %0d want 1", score); else passes++;
    endtask

    task automatic test_miss_hold();
        do_reset();
        place(3'b110, 25);
        do_tick(3'b000, 1'b0);
        checks++; if (miss_count !== 8'd1) $display("FAIL miss_count: got %0d want 1", miss_count); else passes++;
        checks++; if (indicator !== 2'b01) $display("FAIL miss_indicator: got %b want 01", indicator); else passes++;
        checks++; if (arrow_array !== '0) $display("FAIL miss_array: got %h want 0", arrow_array); else passes++;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            checks++;
            if (indicator !== 2'b01) $display("FAIL hold_c%0d: got %b want 01", k, indicator);
            else passes++;
        end
        cycle();
        checks++; if (indicator !== 2'b00) $display("FAIL hold_expire: got %b want 00", indicator); else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        do_tick(3'b001, 1'b1);
        do_tick(3'b100, 1'b1);
        repeat (24) do_tick(3'b000, 1'b0);
        wait_ready();
        press = 3'b001;
        press_valid = 1'b1;
        cycle();
        press_valid = 1'b0;
        press = 3'b000;
        checks++; if (indicator !== 2'b11) $display("FAIL sim_indicator: got %b want 11", indicator); else passes++;
        checks++; if (score !== 16'd2) $display("FAIL sim_score: got %0d want 2", score); else passes++;
        checks++; if (miss_count !== 8'd0) $display("FAIL sim_miss: got %0d want 0", miss_count); else passes++;
        checks++; if (slot_of(arrow_array, 25) !== 3'b100) $display("FAIL sim_slot25: got %b want 100", slot_of(arrow_array, 25)); else passes++;
        checks++; if (slot_of(arrow_array, 24) !== 3'b000) $display("FAIL sim_slot24: got %b want 000", slot_of(arrow_array, 24)); else passes++;
    endtask

    task automatic test_pause_reset();
        logic [77:0] exp_arr;
        do_reset();
        place(3'b010, 25);
        cycle();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                press = 3'b010;
                press_valid = 1'b1;
            end
            cycle();
            press_valid = 1'b0;
            press = 3'b000;
            checks++;
            if (next_ready !== 1'b0) $display("FAIL pause_ready_c%0d: got %b want 0", k, next_ready);
            else passes++;
        end
        exp_arr = '0;
        exp_arr[77:75] = 3'b010;
        checks++; if (arrow_array !== exp_arr) $display("FAIL pause_array: got %h want %h", arrow_array, exp_arr); else passes++;
        checks++; if (score !== 16'd0) $display("FAIL pause_score: got %0d want 0", score); else passes++;
        checks++; if (indicator !== 2'b00) $display("FAIL pause_indicator: got %b want 00", indicator); else passes++;
        enable = 1'b1;
        cycle();
        checks++; if (next_ready !== 1'b0) $display("FAIL resume_ready_early: got %b want 0", next_ready); else passes++;
        hit(3'b010);
        checks++; if (next_ready !== 1'b1) $display("FAIL resume_ready: got %b want 1", next_ready); else passes++;
        checks++; if (score !== 16'd2) $display("FAIL resume_score: got %0d want 2", score); else passes++;
        checks++; if (indicator !== 2'b11) $display("FAIL resume_indicator: got %b want 11", indicator); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (arrow_array !== '0) $display("FAIL areset_array: got %h want 0", arrow_array); else passes++;
        checks++; if (score !== 16'd0) $display("FAIL areset_score: got %0d want 0", score); else passes++;
        checks++; if (indicator !== 2'b00) $display("FAIL areset_indicator: got %b want 00", indicator); else passes++;
        checks++; if (next_ready !== 1'b0) $display("FAIL areset_ready: got %b want 0", next_ready); else passes++;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        reset_s = 1'b0;
        repeat (26) begin
            wait_ready_s();
            cycle();
        end
        for (int k = 0; k < 32767; k++) begin
            press_valid_s = 1'b1;
            cycle();
            press_valid_s = 1'b0;
            wait_ready_s();
            cycle();
        end
        checks++; if (score_s !== 16'hFFFE) $display("FAIL sat_near: got %h want FFFE", score_s); else passes++;
        press_valid_s = 1'b1;
        cycle();
        press_valid_s = 1'b0;
        checks++; if (score_s !== 16'hFFFF) $display("FAIL sat_reach: got %h want FFFF", score_s); else passes++;
        wait_ready_s();
        cycle();
        press_valid_s = 1'b1;
        cycle();
        press_valid_s = 1'b0;
        checks++; if (score_s !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", score_s); else passes++;
        checks++; if (indicator_s !== 2'b11) $display("FAIL sat_indicator: got %b want 11", indicator_s); else passes++;
        checks++; if (miss_count_s !== 8'd0) $display("FAIL sat_miss: got %0d want 0", miss_count_s); else passes++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handshake();
        test_excellent();
        test_good_bad();
        test_miss_hold();
        test_simultaneous();
        test_pause_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/arrow_lane_sequencer.md
Name: arrow_lane_sequencer

Overview:
- Produces the scrolling arrow state for one player: a 26-slot arrow shift register, flattened onto arrow_array in the 78-bit layout the VGA index logic consumes.
- Pulls chart arrows from a song source through a valid/ready handshake and judges player presses against arrows near the target block.
- Drives indicator and score for that player; the design instantiates one sequencer per player.

Parameters:
- NUM_SLOTS, 26, arrow slots; arrow_array width is 3*NUM_SLOTS.
- STEP_CYCLES, 3125000, clock cycles per scroll step (16 steps/s at 50 MHz); minimum 2.
- HOLD_CYCLES, 25000000, cycles a judgement stays on indicator; minimum 1.
- EXCELLENT_SLOT, 25, slot that scores excellent.
- GOOD_SLOT, 24, slot that scores good.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  game running; low = paused.
- clear  in  1  synchronous flush of slots, score, indicator and step counter.
- next_arrow  in  3  chart arrow code: 000 none, 001 up, 010 left, 011 down, 100 right, 110 shake.
- next_valid  in  1  next_arrow is valid.
- next_ready  out  1  consumes next_arrow this cycle.
- press  in  3  pressed arrow code, same encoding.
- press_valid  in  1  single-cycle press strobe.
- arrow_array  out  3*NUM_SLOTS  slot k at bits [3k+2:3k]; slot 0 is the top of the screen.
- indicator  out  2  11 excellent, 10 good, 01 bad, 00 none.
- score  out  16  accumulated score.
- miss_count  out  8  arrows that left slot NUM_SLOTS-1 unjudged.

Behaviour:
- Reset (async) or clear (sync): all slots 000; indicator 00; score 0; miss_count 0; step counter 0; hold counter 0; next_ready 0.
- Step counter: counts while enable=1. At count STEP_CYCLES-1 it asserts internal tick and wraps to 0. enable=0 freezes the counter and blocks ticks and judging. Presses while paused are ignored.
- next_ready: combinational, equals tick.
- Scroll on tick: slot k+1 <= slot k for k = 0..NUM_SLOTS-2. Slot 0 <= next_arrow if next_valid, else 000. A handshake occurs only when next_valid and next_ready are both high.
- Miss on tick: slot NUM_SLOTS-1 is nonzero before the shift. miss_count +1, saturating at 255; indicator <= 01.
- Press judging (enable=1, press_valid=1, press nonzero): search slots NUM_SLOTS-1 down to GOOD_SLOT-1 (default 25, 24, 23) for code == press. Take the highest-numbered match.
  - Match in EXCELLENT_SLOT: indicator 11, score +2.
  - Match in GOOD_SLOT: indicator 10, score +1.
  - Match in any other searched slot: indicator 01, score unchanged.
  - Any match: the matched slot is cleared to 000.
  - No match: indicator 01, score unchanged, no slot change.
  - press = 000 is ignored.
- Score saturates at 16'hFFFF.
- Press and tick in the same cycle: judge against the pre-shift array, clear the matched slot, then shift. An arrow judged in the last slot therefore does not count as a miss.
- Same-cycle indicator priority: a press result of 11 or 10 beats a miss; otherwise 01.
- Indicator hold: any new judgement or miss loads the hold counter with HOLD_CYCLES-1 and restarts it. The counter decrements each cycle, independent of enable. When it reaches 0 with no new event, indicator returns to 00.
- All outputs are registered except next_ready. Judgement results appear one cycle after press_valid.

Test Plan:
- Reset/handshake: STEP_CYCLES=4; deassert reset; next_valid=1, next_arrow=001 → next_ready pulses every 4th cycle; after first tick arrow_array[2:0]=001; after 26 ticks slot 25 = first arrow.
- Excellent hit: slot 25=010, press=010 → next cycle indicator=11, score=2, slot 25=000, miss_count unchanged at following tick.
- Good vs. bad: slot 24=011 then press=011 → indicator=10, score+1. Separately slot 23=100 with press=100 → indicator=01, slot cleared, score unchanged. Press=001 with no match → 01.
- Miss and hold: HOLD_CYCLES=8; arrow 110 reaches slot 25 unpressed, next tick → miss_count=1, indicator=01 for 8 cycles, then 00.
- Simultaneous press+tick: slot 25=001, press=001 on the tick cycle → indicator=11, score+2, miss_count unchanged; slots shifted with slot 25 taking old slot 24.
- Pause/reset mid-run: enable=0 for 10 cycles → arrow_array, step counter and score frozen, presses ignored. Assert reset asynchronously mid-cycle → all outputs 0 immediately. Score held at FFFF plus an excellent hit → stays FFFF.
